// File: rtl/norm_shifter_if.sv
// Handshake and data bundle for norm_shifter: input beat channel plus result channel.
// The slave modport is the shifter's view; the master modport is the producer/consumer side.
interface norm_shifter_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_data;
  logic [SHIFT_WIDTH-1:0] in_nshift;
  logic                   in_nshift_correct;
  logic                   in_not_zero;

  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [SHIFT_WIDTH:0]   out_shift;
  logic                   out_zero;
  logic                   out_mispredict;

  modport slave (
    input  in_valid, in_data, in_nshift, in_nshift_correct, in_not_zero, out_ready,
    output in_ready, out_valid, out_data, out_shift, out_zero, out_mispredict
  );

  modport master (
    output in_valid, in_data, in_nshift, in_nshift_correct, in_not_zero, out_ready,
    input  in_ready, out_valid, out_data, out_shift, out_zero, out_mispredict
  );
endinterface

// File: rtl/norm_shifter.sv
// Two-stage normalization shifter: S1 applies the predicted coarse shift, S2 the 1-bit fix-up.
// Optional feature: define NORM_CORR_CNT_EN to add the saturating corr_cnt fine-shift counter.
module norm_shifter #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  norm_shifter_if.slave bus
`ifdef NORM_CORR_CNT_EN
  ,
  output logic [15:0]   corr_cnt
`endif
);

  logic                   s1_valid;
  logic [DATA_WIDTH-1:0]  s1_data;
  logic [SHIFT_WIDTH-1:0] s1_nshift;
  logic                   s1_correct;
  logic                   s1_not_zero;

  logic                   out_valid_r;
  logic [DATA_WIDTH-1:0]  out_data_r;
  logic [SHIFT_WIDTH:0]   out_shift_r;
  logic                   out_zero_r;
  logic                   out_mispredict_r;

  logic                   s2_ready;
  logic                   s1_ready;

  logic                   s1_msb;
  logic                   fine;
  logic                   mispredict;
  logic [DATA_WIDTH-1:0]  fine_data;
  logic [SHIFT_WIDTH:0]   fine_shift;

  // A stage can load when it is empty or its contents leave on this edge.
  assign s2_ready = !out_valid_r || bus.out_ready;
  assign s1_ready = !s1_valid || s2_ready;

  assign bus.in_ready       = s1_ready;
  assign bus.out_valid      = out_valid_r;
  assign bus.out_data       = out_data_r;
  assign bus.out_shift      = out_shift_r;
  assign bus.out_zero       = out_zero_r;
  assign bus.out_mispredict = out_mispredict_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s1_nshift   <= '0;
      s1_correct  <= 1'b0;
      s1_not_zero <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data     <= bus.in_data << bus.in_nshift;
        s1_nshift   <= bus.in_nshift;
        s1_correct  <= bus.in_nshift_correct;
        s1_not_zero <= bus.in_not_zero;
      end
    end
  end

  // A zero sum overrides everything; otherwise only an inexact prediction earns the extra shift.
  always_comb begin
    s1_msb     = s1_data[DATA_WIDTH-1];
    fine       = s1_not_zero && !s1_correct && !s1_msb;
    mispredict = s1_not_zero && s1_correct && !s1_msb;
    fine_data  = '0;
    fine_shift = '0;
    if (s1_not_zero) begin
      fine_data  = fine ? {s1_data[DATA_WIDTH-2:0], 1'b0} : s1_data;
      fine_shift = {1'b0, s1_nshift} + {{SHIFT_WIDTH{1'b0}}, fine};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r      <= 1'b0;
      out_data_r       <= '0;
      out_shift_r      <= '0;
      out_zero_r       <= 1'b0;
      out_mispredict_r <= 1'b0;
    end else if (s2_ready) begin
      out_valid_r <= s1_valid;
      if (s1_valid) begin
        out_data_r       <= fine_data;
        out_shift_r      <= fine_shift;
        out_zero_r       <= !s1_not_zero;
        out_mispredict_r <= mispredict;
      end
    end
  end

`ifdef NORM_CORR_CNT_EN
  logic        out_fine_r;
  logic [15:0] corr_cnt_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_fine_r <= 1'b0;
    end else if (s2_ready && s1_valid) begin
      out_fine_r <= fine;
    end
  end

  // Counted on retirement so a stalled beat is never counted twice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      corr_cnt_r <= '0;
    end else if (out_valid_r && bus.out_ready && out_fine_r && (corr_cnt_r != 16'hFFFF)) begin
      corr_cnt_r <= corr_cnt_r + 16'd1;
    end
  end

  assign corr_cnt = corr_cnt_r;
`endif

endmodule
